// File: rtl/std_mem_reader_pkg.sv
// Shared types for the std_mem_d1 stream reader family.
package std_mem_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } reader_state_t;

endpackage

// File: rtl/std_stream_reg.sv
// Registered valid/ready output stage: one skid-free beat register whose
// data and valid hold stable while the consumer stalls.
module std_stream_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             ready,
  output logic             can_load,
  output logic [WIDTH-1:0] dout,
  output logic             valid
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;

  assign can_load = !valid_q || ready;
  assign dout     = data_q;
  assign valid    = valid_q;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (load && can_load) begin
      data_d  = din;
      valid_d = 1'b1;
    end else if (ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/std_mem_d1_reader.sv
// Walks a block of std_mem_d1 addresses and streams each word out with go/done control.
// Optional STD_MEM_READER_STRIDE_EN adds a per-transfer address stride port.
module std_mem_d1_reader
  import std_mem_reader_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int SIZE     = 16,
  parameter int IDX_SIZE = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                go,
  input  logic [IDX_SIZE-1:0] start_addr,
`ifdef STD_MEM_READER_STRIDE_EN
  input  logic [IDX_SIZE-1:0] stride,
`endif
  input  logic [IDX_SIZE:0]   count,
  output logic [IDX_SIZE-1:0] addr0,
  input  logic [WIDTH-1:0]    read_data,
  output logic [WIDTH-1:0]    out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                done
);

  localparam logic [IDX_SIZE:0] SIZE_W = (IDX_SIZE+1)'(SIZE);
  localparam logic [IDX_SIZE:0] ONE_W  = (IDX_SIZE+1)'(1);

  reader_state_t       state_q, state_d;
  logic [IDX_SIZE-1:0] addr_q, addr_d;
  logic [IDX_SIZE:0]   rem_q, rem_d;
  logic                done_q, done_d;
  logic [IDX_SIZE:0]   step_s;
  logic [IDX_SIZE:0]   addr_sum_s;
  logic [IDX_SIZE:0]   addr_wrap_s;
  logic                load_s;
  logic                sr_ready_s;
  logic                can_load_s;

`ifdef STD_MEM_READER_STRIDE_EN
  logic [IDX_SIZE-1:0] stride_q, stride_d;
  assign step_s = {1'b0, stride_q};
`else
  assign step_s = ONE_W;
`endif

  // Extra bit keeps the sum from overflowing; one conditional subtract wraps it.
  assign addr_sum_s  = {1'b0, addr_q} + step_s;
  assign addr_wrap_s = (addr_sum_s >= SIZE_W) ? (addr_sum_s - SIZE_W) : addr_sum_s;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    load_s     = 1'b0;
    sr_ready_s = 1'b0;
`ifdef STD_MEM_READER_STRIDE_EN
    stride_d   = stride_q;
`endif
    case (state_q)
      IDLE: begin
        if (go) begin
          if (count != '0) begin
            state_d = RUN;
            addr_d  = start_addr;
            rem_d   = count;
`ifdef STD_MEM_READER_STRIDE_EN
            stride_d = stride;
`endif
          end else begin
            state_d = DONE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        sr_ready_s = out_ready;
        if (can_load_s) begin
          load_s = 1'b1;
          addr_d = addr_wrap_s[IDX_SIZE-1:0];
          rem_d  = rem_q - ONE_W;
          if (rem_q == ONE_W) begin
            state_d = DRAIN;
          end else begin
            state_d = RUN;
          end
        end else begin
          state_d = RUN;
        end
      end
      DRAIN: begin
        sr_ready_s = out_ready;
        if (out_valid && out_ready) begin
          state_d = DONE;
        end else begin
          state_d = DRAIN;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
    end
  end

`ifdef STD_MEM_READER_STRIDE_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stride_q <= '0;
    end else begin
      stride_q <= stride_d;
    end
  end
`endif

  std_stream_reg #(.WIDTH(WIDTH)) u_out (
    .clk      (clk),
    .reset    (reset),
    .load     (load_s),
    .din      (read_data),
    .ready    (sr_ready_s),
    .can_load (can_load_s),
    .dout     (out_data),
    .valid    (out_valid)
  );

  assign addr0 = addr_q;
  assign done  = done_q;

endmodule

// File: tb/tb_std_mem_d1_reader.sv
// Directed, table-driven bench for std_mem_d1_reader with a behavioural memory.
module tb_std_mem_d1_reader;

  localparam int WIDTH = 32;
  localparam int SIZE  = 10;
  localparam int IDX   = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             go;
  logic [IDX-1:0]   start_addr;
  logic [IDX-1:0]   stride;
  logic [IDX:0]     count;
  logic [IDX-1:0]   addr0;
  logic [WIDTH-1:0] read_data;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             done;
  logic [WIDTH-1:0] mem [16];

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign read_data = mem[addr0];

  std_mem_d1_reader #(.WIDTH(WIDTH), .SIZE(SIZE), .IDX_SIZE(IDX)) dut (
    .clk        (clk),
    .reset      (reset),
    .go         (go),
    .start_addr (start_addr),
`ifdef STD_MEM_READER_STRIDE_EN
    .stride     (stride),
`endif
    .count      (count),
    .addr0      (addr0),
    .read_data  (read_data),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .done       (done)
  );

  typedef struct {
    int start;
    int cnt;
    bit stall;
    bit poke;
    int exp_beats;
    int exp_first;
    int exp_done;
    int exp_last;
  } vec_t;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Cycle 0 is the cycle go is high; outputs sampled and inputs driven at negedge.
  task automatic run(input vec_t v, input int step,
                     output int beats, output int first, output int done_c, output int last);
    int          exp_addr;
    bit          stalled;
    int          prev_data;
    int          prev_addr;
    beats = 0; first = -1; done_c = -1; last = -1;
    exp_addr = v.start; stalled = 1'b0; prev_data = 0; prev_addr = 0;
    @(negedge clk);
    go = 1'b1; start_addr = IDX'(v.start); count = (IDX+1)'(v.cnt); out_ready = 1'b1;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(negedge clk);
      if (v.poke && cyc == 3) begin
        go = 1'b1; start_addr = IDX'(7); count = (IDX+1)'(1);
      end else begin
        go = 1'b0;
      end
      if (stalled) begin
        chk("stall_valid", int'(out_valid), 1);
        chk("stall_data", int'(out_data), prev_data);
        chk("stall_addr", int'(addr0), prev_addr);
      end
      if (cyc == 1 && v.cnt != 0) chk("first_addr", int'(addr0), v.start);
      if (done) begin
        done_c = cyc;
        break;
      end
      out_ready = v.stall ? cyc[0] : 1'b1;
      if (out_valid) begin
        if (first < 0) first = cyc;
        if (out_ready) begin
          chk("beat_data", int'(out_data), int'(mem[exp_addr]));
          exp_addr = (exp_addr + step) % SIZE;
          beats++;
          last = int'(out_data);
        end
      end
      stalled   = out_valid && !out_ready;
      prev_data = int'(out_data);
      prev_addr = int'(addr0);
    end
    if (done_c < 0) begin
      n_cmp++; n_fail++;
      $display("FAIL done_timeout: got no done, expected done within 60 cycles");
    end else begin
      @(negedge clk);
      chk("done_one_cycle", int'(done), 0);
      chk("idle_valid", int'(out_valid), 0);
    end
  endtask

  vec_t vecs[7];
  int   b, f, d, l;

  initial begin
    vecs[0] = '{2, 4,  1'b0, 1'b0, 4,  2, 6,  50};
    vecs[1] = '{8, 5,  1'b0, 1'b0, 5,  2, 7,  20};
    vecs[2] = '{2, 4,  1'b1, 1'b0, 4,  2, 10, 50};
    vecs[3] = '{0, 0,  1'b0, 1'b0, 0, -1, 1,  -1};
    vecs[4] = '{9, 12, 1'b0, 1'b0, 12, 2, 14, 0};
    vecs[5] = '{2, 4,  1'b0, 1'b1, 4,  2, 6,  50};
    vecs[6] = '{9, 1,  1'b1, 1'b0, 1,  2, 4,  90};

    for (int i = 0; i < 16; i++) mem[i] = WIDTH'(i * 10);
    reset = 1'b1; go = 1'b0; out_ready = 1'b0; stride = IDX'(1);
    start_addr = '0; count = '0;
    repeat (2) @(negedge clk);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_addr", int'(addr0), 0);
    chk("rst_data", int'(out_data), 0);
    reset = 1'b0;

    for (int i = 0; i < 7; i++) begin
      run(vecs[i], 1, b, f, d, l);
      chk($sformatf("v%0d_beats", i), b, vecs[i].exp_beats);
      chk($sformatf("v%0d_first", i), f, vecs[i].exp_first);
      chk($sformatf("v%0d_done", i), d, vecs[i].exp_done);
      chk($sformatf("v%0d_last", i), l, vecs[i].exp_last);
    end

    // Reset after two of six beats abandons the block without a done.
    @(negedge clk);
    go = 1'b1; start_addr = IDX'(0); count = (IDX+1)'(6); out_ready = 1'b1;
    @(negedge clk); go = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", int'(out_valid), 0);
    chk("mid_rst_done", int'(done), 0);
    chk("mid_rst_addr", int'(addr0), 0);
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("post_rst_done", int'(done), 0);
      chk("post_rst_valid", int'(out_valid), 0);
    end
    run('{0, 1, 1'b0, 1'b0, 1, 2, 3, 0}, 1, b, f, d, l);
    chk("after_rst_beats", b, 1);
    chk("after_rst_done", d, 3);
    chk("after_rst_last", l, 0);

`ifdef STD_MEM_READER_STRIDE_EN
    stride = IDX'(5);
    run('{1, 4, 1'b0, 1'b1, 4, 2, 6, 60}, 5, b, f, d, l);
    chk("stride_beats", b, 4);
    chk("stride_done", d, 6);
    chk("stride_last", l, 60);
    stride = IDX'(1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
